// File: rtl/shift_add_multiplier_haleyorr2027.sv
// shift_add_multiplier_haleyorr2027: sequential 8x8 unsigned shift-add multiplier
// built on adder_8bit_haleyorr2027. Each iteration takes one clock cycle, and the result is a 16-bit {A,Q} product.
module adder_8bit_haleyorr2027 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module shift_add_multiplier_haleyorr2027 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t     r_state;
    logic [7:0] r_m, r_a, r_q;
    logic       r_c;
    logic [2:0] r_cnt;
    logic [7:0] w_sum, w_a;
    logic       w_cout, w_c;

    adder_8bit_haleyorr2027 u_add (.a(r_a), .b(r_m), .sum(w_sum), .cout(w_cout));

    // C is always 0 entering an iteration, so {r_c,r_a} is the "no add" case
    assign {w_c, w_a} = r_q[0] ? {w_cout, w_sum} : {r_c, r_a};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_m     <= a;
                    r_q     <= b;
                    r_a     <= '0;
                    r_c     <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_c     <= 1'b0;
                    r_a     <= {w_c, w_a[7:1]};
                    r_q     <= {w_a[0], r_q[7:1]};
                    r_cnt   <= r_cnt + 3'd1;
                    r_state <= (r_cnt == 3'd7) ? DONE : CALC;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign product = {r_a, r_q};
    assign busy    = (r_state == CALC);
    assign done    = (r_state == DONE);
endmodule
